// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt-acknowledge sequencer: level count,
// FSM state encoding and the vector compose helper.
package pic_pkg;
  localparam int NUM_IR = 8;
  localparam int LVL_W = 3;
  localparam logic [7:0] VEC_MASK = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_ACK1 = 3'd2,
    ST_GAP  = 3'd3,
    ST_ACK2 = 3'd4
  } state_t;

  function automatic logic [7:0] compose_vec(input logic [7:0] base, input logic [LVL_W-1:0] lvl);
    return (base & VEC_MASK) | {5'b0, lvl};
  endfunction
endpackage

// File: rtl/inta_sequencer_if.sv
// CPU-side and cascade signals of the sequencer; master drives requests and
// acknowledge strobes, slave is the sequencer itself.
interface inta_sequencer_if;
  import pic_pkg::*;

  logic              i_inta_n;
  logic [NUM_IR-1:0] i_irr;
  logic [NUM_IR-1:0] i_imr;
  logic [7:0]        i_icw2;
  logic [7:0]        i_icw3;
  logic              i_sp_en;
  logic              i_sngl;
  logic              i_aeoi;
  logic              i_eoi;
  logic [LVL_W-1:0]  i_cas_in;
  logic              o_int;
  logic [NUM_IR-1:0] o_irq_clr;
  logic [NUM_IR-1:0] o_isr;
  logic [LVL_W-1:0]  o_cas_out;
  logic              o_cas_oe;
  logic [7:0]        o_data_out;
  logic              o_data_oe;

  modport master (
    output i_inta_n, i_irr, i_imr, i_icw2, i_icw3, i_sp_en, i_sngl, i_aeoi, i_eoi, i_cas_in,
    input  o_int, o_irq_clr, o_isr, o_cas_out, o_cas_oe, o_data_out, o_data_oe
  );

  modport slave (
    input  i_inta_n, i_irr, i_imr, i_icw2, i_icw3, i_sp_en, i_sngl, i_aeoi, i_eoi, i_cas_in,
    output o_int, o_irq_clr, o_isr, o_cas_out, o_cas_oe, o_data_out, o_data_oe
  );
endinterface

// File: rtl/inta_sequencer_priority_resolver.sv
// Fixed-priority resolver: returns the lowest set index (level 0 highest).
// Purely combinational, no backpressure.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] i_req,
  output logic              o_vld,
  output logic [LVL_W-1:0]  o_idx
);

  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_vld = 1'b1;
        o_idx = LVL_W'(i);
      end
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// Two-pulse INTA sequencer with fully nested priority, cascade and AEOI/EOI.
// All outputs registered; sequence advances only on INTA_N edges.
module inta_sequencer
  import pic_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  inta_sequencer_if.slave  bus
);

  state_t            r_state, w_next;
  logic              r_inta_prev;
  logic [LVL_W-1:0]  r_lvl, w_lvl_nxt;
  logic              r_spur, w_spur_nxt;
  logic              r_sel, w_sel_nxt;
  logic [NUM_IR-1:0] r_isr, w_isr_nxt;
  logic [NUM_IR-1:0] r_irq_clr, w_irq_clr_nxt;
  logic              r_int, w_int_nxt;
  logic              r_cas_oe, w_cas_oe_nxt;
  logic [LVL_W-1:0]  r_cas_out, w_cas_out_nxt;
  logic              r_data_oe, w_data_oe_nxt;
  logic [7:0]        r_data_out, w_data_out_nxt;

  logic [NUM_IR-1:0] w_pend;
  logic              w_pend_vld, w_isr_vld, w_req_ok;
  logic [LVL_W-1:0]  w_best, w_isr_top;
  logic              w_fall, w_rise, w_aeoi_clr, w_busy, w_owner;

  assign w_pend = bus.i_irr & ~bus.i_imr;
  assign w_fall = r_inta_prev & ~bus.i_inta_n;
  assign w_rise = ~r_inta_prev & bus.i_inta_n;

  priority_resolver u_pend_res (.i_req(w_pend), .o_vld(w_pend_vld), .o_idx(w_best));
  priority_resolver u_isr_res  (.i_req(r_isr),  .o_vld(w_isr_vld),  .o_idx(w_isr_top));

  assign w_req_ok = w_pend_vld && (!w_isr_vld || (w_best < w_isr_top));

  always_comb begin
    w_next        = r_state;
    w_lvl_nxt     = r_lvl;
    w_spur_nxt    = r_spur;
    w_sel_nxt     = r_sel;
    w_irq_clr_nxt = '0;
    w_aeoi_clr    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_req_ok) w_next = ST_REQ;
      ST_REQ: begin
        // A fall wins over a lost request so that a withdrawn IRR yields the spurious level.
        if (w_fall) begin
          w_next = ST_ACK1;
          if (w_pend_vld) begin
            w_lvl_nxt     = w_best;
            w_spur_nxt    = 1'b0;
            w_irq_clr_nxt = 8'b1 << w_best;
          end else begin
            w_lvl_nxt  = 3'd7;
            w_spur_nxt = 1'b1;
          end
        end else if (!w_req_ok) begin
          w_next = ST_IDLE;
        end
      end
      ST_ACK1: begin
        if (w_rise) begin
          w_next    = ST_GAP;
          w_sel_nxt = (bus.i_cas_in == bus.i_icw3[2:0]);
        end
      end
      ST_GAP: if (w_fall) w_next = ST_ACK2;
      ST_ACK2: begin
        if (w_rise) begin
          w_next     = ST_IDLE;
          w_aeoi_clr = bus.i_aeoi && !r_spur;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // EOI acts on the ISR as it stood before this cycle's acknowledge sets a bit.
  always_comb begin
    w_isr_nxt = r_isr;
    if (bus.i_eoi && w_isr_vld) w_isr_nxt[w_isr_top] = 1'b0;
    if (w_aeoi_clr) w_isr_nxt[r_lvl] = 1'b0;
    w_isr_nxt = w_isr_nxt | w_irq_clr_nxt;
  end

  always_comb begin
    w_busy         = (w_next == ST_ACK1) || (w_next == ST_GAP) || (w_next == ST_ACK2);
    w_cas_oe_nxt   = w_busy && bus.i_sp_en && !bus.i_sngl && bus.i_icw3[w_lvl_nxt];
    w_cas_out_nxt  = w_cas_oe_nxt ? w_lvl_nxt : '0;
    w_owner        = bus.i_sngl || (bus.i_sp_en && !bus.i_icw3[w_lvl_nxt]) || (!bus.i_sp_en && w_sel_nxt);
    w_data_oe_nxt  = (w_next == ST_ACK2) && w_owner;
    w_data_out_nxt = w_data_oe_nxt ? compose_vec(bus.i_icw2, w_lvl_nxt) : 8'h00;
    w_int_nxt      = (r_state == ST_REQ) && (w_next == ST_REQ);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_inta_prev <= 1'b1;
      r_lvl       <= '0;
      r_spur      <= 1'b0;
      r_sel       <= 1'b0;
      r_isr       <= '0;
      r_irq_clr   <= '0;
      r_int       <= 1'b0;
      r_cas_oe    <= 1'b0;
      r_cas_out   <= '0;
      r_data_oe   <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_state     <= w_next;
      r_inta_prev <= bus.i_inta_n;
      r_lvl       <= w_lvl_nxt;
      r_spur      <= w_spur_nxt;
      r_sel       <= w_sel_nxt;
      r_isr       <= w_isr_nxt;
      r_irq_clr   <= w_irq_clr_nxt;
      r_int       <= w_int_nxt;
      r_cas_oe    <= w_cas_oe_nxt;
      r_cas_out   <= w_cas_out_nxt;
      r_data_oe   <= w_data_oe_nxt;
      r_data_out  <= w_data_out_nxt;
    end
  end

  assign bus.o_int      = r_int;
  assign bus.o_irq_clr  = r_irq_clr;
  assign bus.o_isr      = r_isr;
  assign bus.o_cas_out  = r_cas_out;
  assign bus.o_cas_oe   = r_cas_oe;
  assign bus.o_data_out = r_data_out;
  assign bus.o_data_oe  = r_data_oe;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: one task per scenario, inline checks
// sampled 1ns after the rising edge.
module tb_inta_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inta_sequencer_if bus ();

  inta_sequencer dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_inta(input logic v);
    bus.i_inta_n = v;
    tick();
  endtask

  task automatic wait_int(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = bus.o_int;
    end
  endtask

  task automatic do_reset();
    bus.i_inta_n = 1'b1; bus.i_irr = '0; bus.i_imr = '0; bus.i_icw2 = 8'h40;
    bus.i_icw3 = 8'h05; bus.i_sp_en = 1'b1; bus.i_sngl = 1'b0; bus.i_aeoi = 1'b0;
    bus.i_eoi = 1'b0; bus.i_cas_in = 3'd0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.i_inta_n = 1'b0; bus.i_irr = 8'hFF; bus.i_imr = '0; bus.i_icw2 = 8'h40;
    bus.i_icw3 = 8'hFF; bus.i_sp_en = 1'b1; bus.i_sngl = 1'b0; bus.i_aeoi = 1'b0;
    bus.i_eoi = 1'b0; bus.i_cas_in = 3'd0;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if ({bus.o_int, bus.o_irq_clr, bus.o_isr, bus.o_cas_out, bus.o_cas_oe, bus.o_data_out, bus.o_data_oe} !== 30'h0) begin
      n_bad++; $display("FAIL reset_outputs got int=%b clr=%h isr=%h cas=%h/%b dat=%h/%b want all 0",
        bus.o_int, bus.o_irq_clr, bus.o_isr, bus.o_cas_out, bus.o_cas_oe, bus.o_data_out, bus.o_data_oe); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.i_irr = 8'h02;
    tick();
    n_cmp++; if (bus.o_int !== 1'b0) begin n_bad++; $display("FAIL basic_int_entry got=%b want=0", bus.o_int); end
    tick();
    n_cmp++; if (bus.o_int !== 1'b1) begin n_bad++; $display("FAIL basic_int_req got=%b want=1", bus.o_int); end
    edge_inta(1'b0);
    n_cmp++; if (bus.o_irq_clr !== 8'h02) begin n_bad++; $display("FAIL basic_irq_clr got=%h want=02", bus.o_irq_clr); end
    n_cmp++; if (bus.o_isr !== 8'h02) begin n_bad++; $display("FAIL basic_isr got=%h want=02", bus.o_isr); end
    n_cmp++; if (bus.o_int !== 1'b0) begin n_bad++; $display("FAIL basic_int_ack1 got=%b want=0", bus.o_int); end
    n_cmp++; if (bus.o_cas_oe !== 1'b0) begin n_bad++; $display("FAIL basic_cas_oe got=%b want=0", bus.o_cas_oe); end
    bus.i_irr = 8'h00;
    tick();
    n_cmp++; if (bus.o_irq_clr !== 8'h00) begin n_bad++; $display("FAIL basic_clr_pulse got=%h want=00", bus.o_irq_clr); end
    edge_inta(1'b1);
    n_cmp++; if (bus.o_data_oe !== 1'b0) begin n_bad++; $display("FAIL basic_gap_oe got=%b want=0", bus.o_data_oe); end
    edge_inta(1'b0);
    n_cmp++; if (bus.o_data_oe !== 1'b1) begin n_bad++; $display("FAIL basic_ack2_oe got=%b want=1", bus.o_data_oe); end
    n_cmp++; if (bus.o_data_out !== 8'h41) begin n_bad++; $display("FAIL basic_vector got=%h want=41", bus.o_data_out); end
    edge_inta(1'b1);
    n_cmp++; if ({bus.o_data_oe, bus.o_data_out} !== 9'h0) begin n_bad++; $display("FAIL basic_release got=%b/%h want=0/00", bus.o_data_oe, bus.o_data_out); end
    n_cmp++; if (bus.o_isr !== 8'h02) begin n_bad++; $display("FAIL basic_isr_hold got=%h want=02", bus.o_isr); end
  endtask

  task automatic test_cascade();
    logic seen;
    logic oe_seen;
    do_reset();
    bus.i_irr = 8'h01;
    wait_int(seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL casc_int got=%b want=1", seen); end
    edge_inta(1'b0);
    n_cmp++; if ({bus.o_cas_oe, bus.o_cas_out} !== 4'b1_000) begin n_bad++; $display("FAIL casc_ack1 got=%b/%0d want=1/0", bus.o_cas_oe, bus.o_cas_out); end
    oe_seen = bus.o_data_oe;
    bus.i_irr = 8'h00;
    edge_inta(1'b1);
    oe_seen |= bus.o_data_oe;
    n_cmp++; if (bus.o_cas_oe !== 1'b1) begin n_bad++; $display("FAIL casc_gap got=%b want=1", bus.o_cas_oe); end
    edge_inta(1'b0);
    oe_seen |= bus.o_data_oe;
    n_cmp++; if ({bus.o_cas_oe, bus.o_cas_out} !== 4'b1_000) begin n_bad++; $display("FAIL casc_ack2 got=%b/%0d want=1/0", bus.o_cas_oe, bus.o_cas_out); end
    n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL casc_data_oe got=%b want=0", oe_seen); end
    edge_inta(1'b1);
    n_cmp++; if (bus.o_cas_oe !== 1'b0) begin n_bad++; $display("FAIL casc_release got=%b want=0", bus.o_cas_oe); end
    do_reset();
    bus.i_irr = 8'h04;
    wait_int(seen);
    edge_inta(1'b0);
    n_cmp++; if ({bus.o_cas_oe, bus.o_cas_out} !== 4'b1_010) begin n_bad++; $display("FAIL casc_lvl2 got=%b/%0d want=1/2", bus.o_cas_oe, bus.o_cas_out); end
    bus.i_irr = 8'h00;
    edge_inta(1'b1);
    edge_inta(1'b0);
    edge_inta(1'b1);
  endtask

  task automatic test_slave();
    logic seen;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      bus.i_sp_en = 1'b0; bus.i_icw3 = 8'h02; bus.i_irr = 8'h04;
      bus.i_cas_in = (k == 0) ? 3'd2 : 3'd3;
      wait_int(seen);
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL slave_int[%0d] got=%b want=1", k, seen); end
      edge_inta(1'b0);
      n_cmp++; if ({bus.o_isr, bus.o_cas_oe} !== 9'b00000100_0) begin n_bad++; $display("FAIL slave_ack1[%0d] got isr=%h oe=%b want 04/0", k, bus.o_isr, bus.o_cas_oe); end
      bus.i_irr = 8'h00;
      edge_inta(1'b1);
      bus.i_cas_in = 3'd0;
      edge_inta(1'b0);
      if (k == 0) begin
        n_cmp++; if ({bus.o_data_oe, bus.o_data_out} !== 9'h142) begin n_bad++; $display("FAIL slave_sel got=%b/%h want=1/42", bus.o_data_oe, bus.o_data_out); end
      end else begin
        n_cmp++; if ({bus.o_data_oe, bus.o_data_out} !== 9'h000) begin n_bad++; $display("FAIL slave_unsel got=%b/%h want=0/00", bus.o_data_oe, bus.o_data_out); end
      end
      edge_inta(1'b1);
    end
  endtask

  task automatic test_nesting();
    logic seen;
    logic hi;
    do_reset();
    bus.i_icw3 = 8'h00; bus.i_irr = 8'h04;
    wait_int(seen);
    edge_inta(1'b0);
    bus.i_irr = 8'h00;
    edge_inta(1'b1); edge_inta(1'b0); edge_inta(1'b1);
    n_cmp++; if (bus.o_isr !== 8'h04) begin n_bad++; $display("FAIL nest_isr4 got=%h want=04", bus.o_isr); end
    bus.i_irr = 8'h08;
    hi = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); hi |= bus.o_int; end
    n_cmp++; if (hi !== 1'b0) begin n_bad++; $display("FAIL nest_blocked got=%b want=0", hi); end
    bus.i_irr = 8'h01;
    wait_int(seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL nest_preempt got=%b want=1", seen); end
    edge_inta(1'b0);
    n_cmp++; if (bus.o_isr !== 8'h05) begin n_bad++; $display("FAIL nest_isr5 got=%h want=05", bus.o_isr); end
    bus.i_irr = 8'h00;
    edge_inta(1'b1); edge_inta(1'b0);
    n_cmp++; if (bus.o_data_out !== 8'h40) begin n_bad++; $display("FAIL nest_vector got=%h want=40", bus.o_data_out); end
    edge_inta(1'b1);
    bus.i_eoi = 1'b1; tick(); bus.i_eoi = 1'b0;
    n_cmp++; if (bus.o_isr !== 8'h04) begin n_bad++; $display("FAIL eoi_first got=%h want=04", bus.o_isr); end
    bus.i_eoi = 1'b1; tick(); bus.i_eoi = 1'b0;
    n_cmp++; if (bus.o_isr !== 8'h00) begin n_bad++; $display("FAIL eoi_second got=%h want=00", bus.o_isr); end
    bus.i_eoi = 1'b1; tick(); bus.i_eoi = 1'b0;
    n_cmp++; if (bus.o_isr !== 8'h00) begin n_bad++; $display("FAIL eoi_empty got=%h want=00", bus.o_isr); end
  endtask

  task automatic test_eoi_same_cycle();
    logic seen;
    do_reset();
    bus.i_icw3 = 8'h00; bus.i_irr = 8'h04;
    wait_int(seen);
    edge_inta(1'b0);
    bus.i_irr = 8'h00;
    edge_inta(1'b1); edge_inta(1'b0); edge_inta(1'b1);
    bus.i_irr = 8'h01;
    wait_int(seen);
    bus.i_eoi = 1'b1;
    edge_inta(1'b0);
    bus.i_eoi = 1'b0;
    n_cmp++; if (bus.o_isr !== 8'h01) begin n_bad++; $display("FAIL eoi_with_set got=%h want=01", bus.o_isr); end
    bus.i_irr = 8'h00;
    edge_inta(1'b1); edge_inta(1'b0); edge_inta(1'b1);
  endtask

  task automatic test_spurious();
    logic seen;
    do_reset();
    bus.i_irr = 8'h02;
    wait_int(seen);
    bus.i_irr = 8'h00;
    edge_inta(1'b0);
    n_cmp++; if ({bus.o_irq_clr, bus.o_isr, bus.o_int} !== 17'h0) begin n_bad++; $display("FAIL spur_ack1 got clr=%h isr=%h int=%b want 00/00/0", bus.o_irq_clr, bus.o_isr, bus.o_int); end
    edge_inta(1'b1); edge_inta(1'b0);
    n_cmp++; if ({bus.o_data_oe, bus.o_data_out} !== 9'h147) begin n_bad++; $display("FAIL spur_vector got=%b/%h want=1/47", bus.o_data_oe, bus.o_data_out); end
    edge_inta(1'b1);
    n_cmp++; if (bus.o_isr !== 8'h00) begin n_bad++; $display("FAIL spur_isr got=%h want=00", bus.o_isr); end
    bus.i_irr = 8'h02;
    wait_int(seen);
    bus.i_irr = 8'h00;
    tick();
    n_cmp++; if (bus.o_int !== 1'b0) begin n_bad++; $display("FAIL withdraw_int got=%b want=0", bus.o_int); end
    edge_inta(1'b0); edge_inta(1'b1); edge_inta(1'b0);
    n_cmp++; if ({bus.o_data_oe, bus.o_isr} !== 9'h0) begin n_bad++; $display("FAIL idle_fall got oe=%b isr=%h want 0/00", bus.o_data_oe, bus.o_isr); end
    edge_inta(1'b1);
    bus.i_aeoi = 1'b1; bus.i_irr = 8'h02;
    wait_int(seen);
    edge_inta(1'b0);
    bus.i_irr = 8'h00;
    edge_inta(1'b1); edge_inta(1'b0);
    n_cmp++; if (bus.o_isr !== 8'h02) begin n_bad++; $display("FAIL aeoi_ack2 got=%h want=02", bus.o_isr); end
    edge_inta(1'b1);
    n_cmp++; if (bus.o_isr !== 8'h00) begin n_bad++; $display("FAIL aeoi_clear got=%h want=00", bus.o_isr); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    do_reset();
    bus.i_irr = 8'h01;
    wait_int(seen);
    edge_inta(1'b0);
    bus.i_irr = 8'h00;
    edge_inta(1'b1);
    n_cmp++; if (bus.o_cas_oe !== 1'b1) begin n_bad++; $display("FAIL mid_gap_cas got=%b want=1", bus.o_cas_oe); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({bus.o_int, bus.o_irq_clr, bus.o_isr, bus.o_cas_out, bus.o_cas_oe, bus.o_data_out, bus.o_data_oe} !== 30'h0) begin
      n_bad++; $display("FAIL mid_reset got int=%b clr=%h isr=%h cas=%h/%b dat=%h/%b want all 0",
        bus.o_int, bus.o_irq_clr, bus.o_isr, bus.o_cas_out, bus.o_cas_oe, bus.o_data_out, bus.o_data_oe); end
    rst_n = 1'b1;
    edge_inta(1'b0);
    tick();
    n_cmp++; if ({bus.o_data_oe, bus.o_cas_oe, bus.o_irq_clr, bus.o_isr} !== 18'h0) begin n_bad++; $display("FAIL mid_after got oe=%b cas=%b clr=%h isr=%h want all 0", bus.o_data_oe, bus.o_cas_oe, bus.o_irq_clr, bus.o_isr); end
    edge_inta(1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cascade();
    test_slave();
    test_nesting();
    test_eoi_same_cycle();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 Parameters: none; 8 interrupt levels fixed.
REQ-002 CLK  in  1  single clock; all logic rising-edge.
REQ-003 RST_N  in  1  reset, synchronous, active-low.
REQ-004 INTA_N  in  1  CPU acknowledge strobe, active-low, synchronous to CLK.
REQ-005 IRR  in  8  latched interrupt requests.
REQ-006 IMR  in  8  mask; 1 = level masked.
REQ-007 ICW2  in  8  vector base; bits [7:3] used.
REQ-008 ICW3  in  8  master: slave-present bitmap per level; slave: [2:0] own ID.
REQ-009 SP_EN  in  1  1 = master, 0 = slave.
REQ-010 SNGL  in  1  1 = single mode; cascade logic disabled.
REQ-011 AEOI  in  1  1 = automatic EOI at end of second acknowledge.
REQ-012 EOI  in  1  one-cycle non-specific EOI command.
REQ-013 CAS_IN  in  3  cascade ID from master (slave mode).
REQ-014 INT  out  1  interrupt to CPU, registered.
REQ-015 IRQ_CLR  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit.
REQ-016 ISR  out  8  in-service register.
REQ-017 CAS_OUT  out  3  cascade ID driven by master; CAS_OE  out  1  enable.
REQ-018 DATA_OUT  out  8  vector; DATA_OE  out  1  enable.

Function
REQ-019 pend = IRR & ~IMR; priority fixed, level 0 highest; best = lowest set index of pend.
REQ-020 req_ok when pend != 0 and best is of higher priority than the highest set ISR bit (fully nested); req_ok is true when ISR == 0.
REQ-021 Edge detect: fall = prev INTA_N & ~INTA_N; rise = ~prev & INTA_N; prev resets to 1.
REQ-022 FSM states IDLE, REQ, ACK1, GAP, ACK2.
REQ-023 IDLE -> REQ when req_ok; INT = 1 from the cycle after entry into REQ until leaving REQ.
REQ-024 REQ: if req_ok is lost before fall, return to IDLE and drop INT.
REQ-025 REQ -> ACK1 on fall: latch lvl = best; set ISR[lvl]; pulse IRQ_CLR[lvl]; INT = 0 next cycle.
REQ-026 fall with pend == 0 in REQ: lvl = 7 (spurious); no ISR set; no IRQ_CLR.
REQ-027 ACK1 -> GAP on rise; GAP -> ACK2 on fall; ACK2 -> IDLE on rise.
REQ-028 Master, SNGL = 0, ICW3[lvl] = 1: CAS_OE = 1, CAS_OUT = lvl from entry to ACK1 through exit from ACK2; otherwise CAS_OE = 0, CAS_OUT = 0.
REQ-029 Slave: CAS_IN is sampled on entry to GAP; sel = (CAS_IN == ICW3[2:0]).
REQ-030 Vector owner: SNGL = 1; or master with ICW3[lvl] = 0; or slave with sel = 1.
REQ-031 ACK2 with owner: DATA_OE = 1, DATA_OUT = {ICW2[7:3], lvl}; otherwise DATA_OE = 0, DATA_OUT = 0.
REQ-032 AEOI = 1: clear ISR[lvl] on the ACK2 -> IDLE transition; no clear for spurious.
REQ-033 EOI clears the highest-priority set ISR bit; EOI with ISR == 0 has no effect.
REQ-034 EOI and ISR set in the same cycle: EOI is evaluated on the old ISR, then the set is applied.
REQ-035 fall in IDLE, ACK1 or ACK2 is ignored; rise in REQ or GAP is ignored.

Reset
REQ-036 RST_N = 0 at a rising CLK edge: FSM = IDLE; ISR, IRQ_CLR, CAS_OUT and DATA_OUT = 0; INT, CAS_OE and DATA_OE = 0; prev INTA_N = 1; lvl = 0.
REQ-037 Reset mid-sequence (any state) aborts the sequence with no further IRQ_CLR pulse and releases the buses in the same edge.

Structure
REQ-038 Shared package pic_pkg holds: NUM_IR = 8, the state encoding, and the vector-compose constant mask 8'hF8.
REQ-039 One sub-module, priority_resolver (combinational: 8-bit in -> valid and 3-bit index), is used for both pend and ISR.

Verification
REQ-040 Master, SNGL = 0, ICW3 = 8'h05, ICW2 = 8'h40, IRR = 8'h02, two INTA_N pulses -> INT = 1, then IRQ_CLR = 8'h02, ISR = 8'h02, CAS_OE = 0, DATA_OUT = 8'h41 during ACK2.
REQ-041 Same configuration, IRR = 8'h01 -> CAS_OE = 1, CAS_OUT = 0 through both pulses, DATA_OE never 1.
REQ-042 Slave, ICW3 = 8'h02, IRR = 8'h04, CAS_IN = 3'd2 -> DATA_OUT = 8'h42; repeat with CAS_IN = 3'd3 -> DATA_OE stays 0.
REQ-043 ISR = 8'h04 in service, IRR = 8'h08 -> INT stays 0; then IRR = 8'h01 -> INT = 1; EOI -> ISR[0] cleared first.
REQ-044 IRR cleared after INT, before the first fall -> vector 8'h47 with ISR unchanged; AEOI = 1 run -> ISR = 0 after ACK2.
REQ-045 RST_N low during GAP -> next cycle state IDLE, all outputs 0.
